// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: mode codes, bounce
// direction and the default base pattern.
package led_seq_pkg;

    localparam logic [1:0] MODE_ROL    = 2'b00;
    localparam logic [1:0] MODE_ROR    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [11:0] DEFAULT_PATTERN = 12'b000011101101;

endpackage

// File: rtl/led_prescaler.sv
// Programmable prescaler: emits a one-cycle advance every div+1 enabled
// cycles. clr restarts the period from zero.
module led_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             clr,
    output logic             adv
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    // >= rather than == so that lowering div below the count fires at once.
    always_comb begin
        adv     = en && (count_q >= div);
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (adv) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: rotates or bounces a WIDTH-bit pattern on each
// prescaled advance, with runtime reload of the pattern.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int               WIDTH   = 12,
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEFAULT_PATTERN),
    parameter int               DIV_W   = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [DIV_W-1:0]           div,
    input  logic                       load,
    input  logic [WIDTH-1:0]           load_pattern,
    output logic [WIDTH-1:0]           leds,
    output logic                       tick,
    output logic [$clog2(WIDTH)-1:0]   pos
);

    localparam int               POS_W   = $clog2(WIDTH);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);

    logic [WIDTH-1:0] leds_q, leds_d;
    logic [POS_W-1:0] pos_q, pos_d;
    dir_t             dir_q, dir_d;
    logic             tick_q, tick_d;
    logic             adv;

    logic [WIDTH-1:0] leds_rol, leds_ror;
    logic [POS_W-1:0] pos_inc, pos_dec;
    dir_t             bounce_dir;

    led_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .div   (div),
        .clr   (load),
        .adv   (adv)
    );

    assign leds_rol = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
    assign leds_ror = {leds_q[0], leds_q[WIDTH-1:1]};
    assign pos_inc  = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
    assign pos_dec  = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;

    // Turn around before stepping so each end position is shown only once.
    always_comb begin
        bounce_dir = dir_q;
        if (dir_q == DIR_LEFT && pos_q == POS_MAX) begin
            bounce_dir = DIR_RIGHT;
        end else if (dir_q == DIR_RIGHT && pos_q == '0) begin
            bounce_dir = DIR_LEFT;
        end
    end

    always_comb begin
        leds_d = leds_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        if (load) begin
            leds_d = load_pattern;
            pos_d  = '0;
            dir_d  = DIR_LEFT;
        end else if (adv) begin
            tick_d = 1'b1;
            case (mode)
                MODE_ROL: begin
                    leds_d = leds_rol;
                    pos_d  = pos_inc;
                    dir_d  = DIR_LEFT;
                end
                MODE_ROR: begin
                    leds_d = leds_ror;
                    pos_d  = pos_dec;
                    dir_d  = DIR_RIGHT;
                end
                MODE_BOUNCE: begin
                    dir_d = bounce_dir;
                    if (bounce_dir == DIR_LEFT) begin
                        leds_d = leds_rol;
                        pos_d  = pos_inc;
                    end else begin
                        leds_d = leds_ror;
                        pos_d  = pos_dec;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            leds_q <= PATTERN;
            pos_q  <= '0;
            dir_q  <= DIR_LEFT;
            tick_q <= 1'b0;
        end else begin
            leds_q <= leds_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
        end
    end

    assign leds = leds_q;
    assign pos  = pos_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: behavioural model compared every cycle, plus
// directed literal checks and a small 4-LED bounce instance.
module tb_led_pattern_seq;

    localparam int          W   = 12;
    localparam logic [11:0] PAT = 12'b000011101101;

    logic        clk = 1'b0;
    logic        rst_n, en, load;
    logic [1:0]  mode;
    logic [23:0] div;
    logic [11:0] load_pattern, leds;
    logic        tick;
    logic [3:0]  pos;

    logic        b_rst_n, b_en, b_load;
    logic [1:0]  b_mode;
    logic [7:0]  b_div;
    logic [3:0]  b_load_pattern, b_leds;
    logic        b_tick;
    logic [1:0]  b_pos;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pattern_seq u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div(div),
        .load(load), .load_pattern(load_pattern),
        .leds(leds), .tick(tick), .pos(pos)
    );

    led_pattern_seq #(.WIDTH(4), .PATTERN(4'b0001), .DIV_W(8)) u_dut4 (
        .clk(clk), .rst_n(b_rst_n), .en(b_en), .mode(b_mode), .div(b_div),
        .load(b_load), .load_pattern(b_load_pattern),
        .leds(b_leds), .tick(b_tick), .pos(b_pos)
    );

    // ---------------- behavioural model ----------------
    logic [11:0] m_leds;
    int          m_pos;
    int          m_dir;   // 0 = moving left, 1 = moving right
    longint      m_cnt;
    logic        m_tick;
    bit          m_valid = 1'b0;

    function automatic logic [11:0] rot_l(input logic [11:0] x);
        int v;
        v = int'(x);
        return 12'(((v * 2) + (v / 2048)) % 4096);
    endfunction

    function automatic logic [11:0] rot_r(input logic [11:0] x);
        int v;
        v = int'(x);
        return 12'((v / 2) + (v % 2) * 2048);
    endfunction

    always @(posedge clk) begin
        bit fire;
        int nd;
        if (!rst_n) begin
            m_leds <= PAT; m_pos <= 0; m_dir <= 0; m_cnt <= 0; m_tick <= 1'b0;
            m_valid <= 1'b1;
        end else if (load) begin
            m_leds <= load_pattern; m_pos <= 0; m_dir <= 0; m_cnt <= 0; m_tick <= 1'b0;
        end else begin
            fire = en && (m_cnt >= longint'(div));
            if (en) m_cnt <= fire ? 0 : m_cnt + 1;
            m_tick <= fire;
            if (fire) begin
                case (mode)
                    2'd0: begin m_leds <= rot_l(m_leds); m_pos <= (m_pos + 1) % W; m_dir <= 0; end
                    2'd1: begin m_leds <= rot_r(m_leds); m_pos <= (m_pos + W - 1) % W; m_dir <= 1; end
                    2'd2: begin
                        nd = m_dir;
                        if (m_dir == 0 && m_pos == W - 1) nd = 1;
                        else if (m_dir == 1 && m_pos == 0) nd = 0;
                        m_dir <= nd;
                        if (nd == 0) begin m_leds <= rot_l(m_leds); m_pos <= (m_pos + 1) % W; end
                        else begin m_leds <= rot_r(m_leds); m_pos <= (m_pos + W - 1) % W; end
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (leds !== m_leds || pos !== 4'(m_pos) || tick !== m_tick) begin
                errors++;
                $display("FAIL model_cmp t=%0t leds=%b exp=%b pos=%0d exp=%0d tick=%b exp=%b",
                         $time, leds, m_leds, pos, m_pos, tick, m_tick);
            end
        end
    end

    // ---------------- driver helpers ----------------
    int tick_sum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick_sum += int'(tick);
        end
    endtask

    logic [3:0] exp_b_leds [7];
    int         exp_b_pos  [7];

    initial begin
        exp_b_leds = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        exp_b_pos  = '{1, 2, 3, 2, 1, 0, 1};

        rst_n = 1'b0; en = 1'b0; mode = 2'd0; div = '0; load = 1'b0; load_pattern = '0;
        b_rst_n = 1'b0; b_en = 1'b0; b_mode = 2'd2; b_div = '0; b_load = 1'b0; b_load_pattern = '0;
        tick_sum = 0;
        step(2);
        chk("reset_leds", 32'(leds), 32'(PAT));
        chk("reset_pos", 32'(pos), 0);
        chk("reset_tick", 32'(tick), 0);

        // 4-LED bounce
        b_rst_n = 1'b1; b_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk($sformatf("bounce_leds_%0d", i), 32'(b_leds), 32'(exp_b_leds[i]));
            chk($sformatf("bounce_pos_%0d", i), 32'(b_pos), 32'(exp_b_pos[i]));
        end

        // rotate-left
        rst_n = 1'b1; en = 1'b1; mode = 2'd0; div = '0;
        step(1);
        chk("rol_first", 32'(leds), 32'(12'b000111011010));
        chk("rol_first_tick", 32'(tick), 1);
        step(11);
        chk("rol_wrap_leds", 32'(leds), 32'(PAT));
        chk("rol_wrap_pos", 32'(pos), 0);

        // rotate-right
        mode = 2'd1;
        step(1);
        chk("ror_first", 32'(leds), 32'(12'b100001110110));
        chk("ror_first_pos", 32'(pos), 11);
        step(11);
        chk("ror_wrap_leds", 32'(leds), 32'(PAT));

        // prescale and enable
        mode = 2'd0; div = 24'd3; load = 1'b1; load_pattern = PAT;
        step(1);
        load = 1'b0; tick_sum = 0;
        step(12);
        chk("div3_ticks", 32'(tick_sum), 3);
        en = 1'b0; tick_sum = 0;
        step(5);
        chk("en_low_ticks", 32'(tick_sum), 0);
        chk("en_low_frozen", 32'(leds), 32'(12'b011101101000));
        en = 1'b1; tick_sum = 0;
        step(3);
        chk("resume_no_tick", 32'(tick_sum), 0);
        step(1);
        chk("resume_phase", 32'(tick), 1);
        step(2);
        div = '0;
        step(1);
        chk("div_lowered", 32'(tick), 1);

        // load collision
        div = 24'd3; load = 1'b1; load_pattern = PAT;
        step(1);
        load = 1'b0;
        step(3);
        load = 1'b1; load_pattern = 12'b101010101010;
        step(1);
        chk("coll_leds", 32'(leds), 32'(12'b101010101010));
        chk("coll_pos", 32'(pos), 0);
        chk("coll_tick", 32'(tick), 0);
        load = 1'b0; tick_sum = 0;
        step(3);
        chk("coll_gap", 32'(tick_sum), 0);
        step(1);
        chk("coll_next_tick", 32'(tick), 1);

        // reset mid-bounce, then hold
        mode = 2'd2; div = '0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                step(1);
                if (pos == 4'd5) seen = 1'b1;
            end
            chk("bounce_reach_pos5", 32'(seen), 1);
        end
        rst_n = 1'b0;
        step(1);
        chk("midrst_leds", 32'(leds), 32'(PAT));
        chk("midrst_pos", 32'(pos), 0);
        chk("midrst_tick", 32'(tick), 0);
        rst_n = 1'b1; mode = 2'd3;
        step(2);
        chk("hold_tick", 32'(tick), 1);
        chk("hold_leds", 32'(leds), 32'(PAT));

        // randomized run
        for (int i = 0; i < 2000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            en    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) div  = 24'($urandom_range(0, 5));
            load = ($urandom_range(0, 39) == 0);
            load_pattern = 12'($urandom);
            step(1);
        end

        rst_n = 1'b1; load = 1'b0;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_seq.md
# led_pattern_seq

Parametrised LED pattern sequencer that drives a `WIDTH`-bit LED bank from a base pattern. It advances the pattern on a programmable prescaled tick, in one of four modes: rotate-left, rotate-right, bounce (ping-pong) or hold. The pattern can be reloaded at runtime. It sits between the board clock and the LED pins, replacing the fixed 12-bit rotating LED register, and is driven by a simple control register or by switches.

## Interface

Parameters:
- `WIDTH`, 12: LED count; must be ≥ 2.
- `PATTERN`, 12'b000011101101: reset/base pattern, `WIDTH` bits.
- `DIV_W`, 24: prescaler width.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `en`, in, 1: run enable for the prescaler.
- `mode`, in, 2: 00 rotate-left, 01 rotate-right, 10 bounce, 11 hold.
- `div`, in, `DIV_W`: tick period is `div`+1 enabled cycles.
- `load`, in, 1: synchronous pattern load strobe.
- `load_pattern`, in, `WIDTH`: value captured on `load`.
- `leds`, out, `WIDTH`: registered LED pattern.
- `tick`, out, 1: one-cycle pulse, registered, marking each advance.
- `pos`, out, `$clog2(WIDTH)`: step index of the current pattern.

## Operation

- **Reset** (`rst_n`=0 at an edge):
  - `leds`=`PATTERN`, `pos`=0, `tick`=0, prescaler count=0, `dir`=LEFT.
  - Reset overrides `load` and `tick`.
  - Reset mid-sequence restores these values on the next edge.
- **Prescaler:**
  - While `en`=1: if count ≥ `div`, count←0 and an advance fires; otherwise count←count+1.
  - While `en`=0: count frozen, no advance.
  - `div`=0 gives an advance on every enabled cycle.
  - Lowering `div` below the current count causes an advance on the next enabled edge (≥ compare).
- **Advance, by `mode` sampled at the advancing edge:**
  - **Rotate-left:** `leds`←{`leds`[W-2:0], `leds`[W-1]}; `pos`←(`pos`+1) mod W; `dir`←LEFT.
  - **Rotate-right:** `leds`←{`leds`[0], `leds`[W-1:1]}; `pos`←`pos`-1 mod W (0 wraps to W-1); `dir`←RIGHT.
  - **Bounce:**
    - Next direction: RIGHT if `dir`=LEFT and `pos`=W-1; LEFT if `dir`=RIGHT and `pos`=0; otherwise unchanged.
    - Rotate one step in the next direction; `pos` moves ±1; `dir`←next direction.
    - End positions are shown once, never repeated.
  - **Hold:** `leds`, `pos` and `dir` unchanged; `tick` still pulses.
- **Load** (`load`=1, `rst_n`=1):
  - `leds`←`load_pattern`, `pos`←0, count←0, `dir`←LEFT, `tick`←0.
  - Load wins over a coincident advance; that advance is dropped.
  - Load acts regardless of `en`.
- **Mode change:** takes effect at the next advance. No pattern reset occurs on a mode change.

## Timing

- `leds`, `pos` and `tick` are all registered from the same edge. `tick`=1 during exactly the cycle in which the new `leds` value is first visible.
- From `en` 0→1 with count=0, the first advance is at the (`div`+1)-th enabled edge. Thereafter advances occur every `div`+1 enabled cycles.
- `load` latency: `load_pattern` appears on `leds` one edge after `load` is sampled.
- Reset is released on the edge where `rst_n`=1. The first advance follows `div`+1 edges later if `en`=1.
- Rotate modes return to the original pattern after exactly W advances.
- A full bounce period is 2(W-1) advances.

## Structure

- Shared package `led_seq_pkg`:
  - Mode encodings `MODE_ROL`, `MODE_ROR`, `MODE_BOUNCE`, `MODE_HOLD`.
  - Direction constants `DIR_LEFT` and `DIR_RIGHT`.
  - Default `PATTERN`.
- One sub-module, `led_prescaler` (parameter `DIV_W`; ports `clk`, `rst_n`, `en`, `div`, `clr`, `adv`). It generates the one-cycle advance strobe; `clr` is driven by `load`.
- The top level holds the `leds`, `pos` and `dir` registers and the mode next-state logic.

## Test plan

- **Rotate-left:** reset, W=12, `mode`=00, `div`=0, `en`=1 → `leds`=000111011010 after 1 tick; 000011101101 and `pos`=0 again after 12 ticks.
- **Rotate-right:** `mode`=01, `div`=0 → first `leds`=100001110110 with `pos`=11; original pattern after 12 ticks.
- **Bounce:** W=4, `PATTERN`=0001, `mode`=10, `div`=0 → `leds` sequence 0010, 0100, 1000, 0100, 0010, 0001, 0010; `pos` 1, 2, 3, 2, 1, 0, 1.
- **Prescale and enable:** `div`=3 → `tick` every 4th cycle. Drop `en` for 5 cycles → no tick, `leds` frozen. Restore `en` → ticks resume with phase held. Set `div`=0 while count=2 → tick on the next edge.
- **Load collision:** `load`=1 with `load_pattern`=101010101010 on an advance cycle → `leds`=101010101010, `pos`=0, `tick`=0. The next tick occurs `div`+1 cycles later.
- **Reset mid-run and hold:** `rst_n`=0 during bounce at `pos`=5 → next edge `leds`=`PATTERN`, `pos`=0, `tick`=0. `mode`=11 → `tick` pulses and `leds` is unchanged.
